match_pair_collector: RTL and testbench
=======================================

Name: match_pair_collector

Overview:
- Sink-side partner of the matcher output stream: accepts per-frame matched keypoint pairs (frame_start / valid / frame_end plus src/dst coordinate and depth), filters out pairs with invalid depth, and buffers them in a FIFO.
- Re-emits pairs to the downstream pose solver over a valid/ready handshake.
- At the end of each frame it drains, then pulses frame-done with per-frame accept/drop statistics.

Parameters:
- DEPTH, 64, FIFO entries (power of two, ≥2)
- CNT_W, 10, width of the per-frame match and drop counters

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_frame_start  in  1  frame begin pulse from matcher
- i_frame_end  in  1  frame end pulse from matcher
- i_valid  in  1  pair on i_src_*/i_dst_* is valid this cycle
- i_src_coor_x / i_src_coor_y / i_src_depth  in  10 each  source keypoint
- i_dst_coor_x / i_dst_coor_y / i_dst_depth  in  10 each  destination keypoint
- o_valid  out  1  output pair valid
- i_ready  in  1  downstream accepts pair
- o_src_coor_x / o_src_coor_y / o_src_depth  out  10 each  buffered source keypoint
- o_dst_coor_x / o_dst_coor_y / o_dst_depth  out  10 each  buffered destination keypoint
- o_frame_done  out  1  one-cycle pulse: frame ended and fully drained
- o_match_count  out  CNT_W  pairs stored this frame
- o_drop_count  out  CNT_W  pairs dropped this frame (depth filter + overflow)
- o_overflow  out  1  sticky per frame: at least one pair lost to FIFO full
- o_proto_err  out  1  sticky until reset: start/end protocol violation

Behaviour:
- Reset (i_rst=1 at a rising edge): state IDLE, FIFO empty, all outputs 0. Applies mid-frame; buffered pairs are discarded.
- States: IDLE, COLLECT, DRAIN.
- IDLE:
  - i_frame_start → COLLECT; clear o_match_count, o_drop_count, o_overflow.
  - i_valid is ignored (not counted), including in the same cycle as i_frame_start.
  - i_frame_end is ignored and sets o_proto_err.
- COLLECT:
  - Each i_valid cycle with both depths nonzero is a push candidate.
  - A pair with either depth == 0 is dropped and o_drop_count++.
  - A push candidate with registered full=1 is dropped: o_drop_count++, o_overflow=1. A pop in the same cycle does not free a slot for that push.
  - Otherwise the pair is written and o_match_count++.
  - i_frame_end → DRAIN; a valid pair in the same cycle is processed first.
  - i_frame_start sets o_proto_err and is otherwise ignored; the frame continues.
- DRAIN:
  - i_valid is ignored. i_frame_start and i_frame_end set o_proto_err and are ignored.
  - When the FIFO is empty, o_frame_done=1 for exactly that cycle and the next state is IDLE.
- Counters saturate at 2^CNT_W−1. Counts hold from o_frame_done until the next accepted i_frame_start.
- Output side (active in all states):
  - o_valid = FIFO not empty. o_* data comes from registered FIFO head.
  - Pop occurs when o_valid && i_ready.
  - While o_valid=1 && i_ready=0, data stays stable.
  - Order is strictly FIFO.
- Latency:
  - Pair pushed at edge T is visible (o_valid=1) at T+1 if the FIFO was empty.
  - Empty frame: i_frame_end sampled at T → o_frame_done high in cycle T+1.
  - Non-empty frame: o_frame_done is high in the cycle after the final pop handshake.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. full = MSB differ and rest equal; empty = equal. Simultaneous push+pop in a non-full, non-empty FIFO keeps the occupancy unchanged.

Test Plan:
1. Basic frame: reset, start, 3 valid pairs (depths 5/6/7), end, i_ready=1 → 3 outputs in order, first at T+1 after its push; o_frame_done one cycle after the 3rd handshake; o_match_count=3, o_drop_count=0.
2. Backpressure: i_ready=0, push 5 pairs, end; hold 10 cycles; then i_ready=1 → o_valid=1 with head data stable throughout the hold; 5 pairs drain in order; o_frame_done after the 5th pop.
3. Depth filter: 4 pairs, 2nd has src_depth=0 and 3rd has dst_depth=0 → 2 outputs; o_match_count=2, o_drop_count=2, o_overflow=0.
4. Overflow (DEPTH=4): i_ready=0, push 6 valid pairs → first 4 stored, o_match_count=4, o_drop_count=2, o_overflow=1. Release ready after end → 4 outputs, then o_frame_done; next frame_start clears o_overflow.
5. Empty frame and protocol errors:
   - start then end on the next cycle → o_frame_done in the cycle after end, counts 0.
   - i_frame_end in IDLE → o_proto_err=1 and stays set.
   - i_frame_start in COLLECT → o_proto_err=1, frame continues.
6. Reset mid-frame: 3 pairs pushed with i_ready=0, assert i_rst for one cycle → o_valid=0, counts 0, state IDLE; a following full frame behaves exactly as scenario 1.

Source files
------------

// File: rtl/match_pair_collector.sv
// Matched keypoint pair collector: depth-filters incoming pairs per frame, buffers them
// in a FIFO for the pose solver, and reports per-frame accept/drop statistics.
module match_pair_collector #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_start,
  input  logic             i_frame_end,
  input  logic             i_valid,
  input  logic [9:0]       i_src_coor_x,
  input  logic [9:0]       i_src_coor_y,
  input  logic [9:0]       i_src_depth,
  input  logic [9:0]       i_dst_coor_x,
  input  logic [9:0]       i_dst_coor_y,
  input  logic [9:0]       i_dst_depth,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [9:0]       o_src_coor_x,
  output logic [9:0]       o_src_coor_y,
  output logic [9:0]       o_src_depth,
  output logic [9:0]       o_dst_coor_x,
  output logic [9:0]       o_dst_coor_y,
  output logic [9:0]       o_dst_depth,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_match_count,
  output logic [CNT_W-1:0] o_drop_count,
  output logic             o_overflow,
  output logic             o_proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = 60;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             perr_q, perr_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic          empty, full, push, pop, depth_ok;
  logic [DW-1:0] wdata, head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = !empty && i_ready;
  assign depth_ok = (i_src_depth != 10'd0) && (i_dst_depth != 10'd0);
  assign wdata    = {i_src_coor_x, i_src_coor_y, i_src_depth,
                     i_dst_coor_x, i_dst_coor_y, i_dst_depth};

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    perr_d  = perr_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_frame_end) perr_d = 1'b1;
        if (i_frame_start) begin
          state_d = ST_COLLECT;
          match_d = '0;
          drop_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_COLLECT: begin
        // Full is the registered flag: a same-cycle pop never makes room for this push.
        if (i_valid) begin
          if (!depth_ok) begin
            drop_d = sat_inc(drop_q);
          end else if (full) begin
            drop_d = sat_inc(drop_q);
            ovf_d  = 1'b1;
          end else begin
            push    = 1'b1;
            match_d = sat_inc(match_q);
          end
        end
        if (i_frame_start) perr_d = 1'b1;
        if (i_frame_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_frame_start || i_frame_end) perr_d = 1'b1;
        if (empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      match_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      match_q  <= match_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  // Head is masked while empty so stale entries never leak onto the output bus.
  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign {o_src_coor_x, o_src_coor_y, o_src_depth,
          o_dst_coor_x, o_dst_coor_y, o_dst_depth} = head;

  assign o_valid       = !empty;
  assign o_frame_done  = (state_q == ST_DRAIN) && empty;
  assign o_match_count = match_q;
  assign o_drop_count  = drop_q;
  assign o_overflow    = ovf_q;
  assign o_proto_err   = perr_q;

endmodule

// File: tb/tb_match_pair_collector.sv
// Scoreboard bench for match_pair_collector: a DEPTH=64 instance plus a DEPTH=4 /
// CNT_W=3 instance sharing the same stimulus for overflow and saturation cases.
module tb_match_pair_collector;

  logic       i_clk = 1'b0;
  logic       i_rst, i_frame_start, i_frame_end, i_valid, i_ready;
  logic [9:0] sx, sy, sd, dx, dy, dd;

  logic       o_valid, o_frame_done, o_overflow, o_proto_err;
  logic [9:0] osx, osy, osd, odx, ody, odd;
  logic [9:0] o_match_count, o_drop_count;

  logic       o4_valid, o4_frame_done, o4_overflow, o4_proto_err;
  logic [9:0] o4sx, o4sy, o4sd, o4dx, o4dy, o4dd;
  logic [2:0] o4_match_count, o4_drop_count;

  logic [59:0] o_pair, o4_pair;
  assign o_pair  = {osx, osy, osd, odx, ody, odd};
  assign o4_pair = {o4sx, o4sy, o4sd, o4dx, o4dy, o4dd};

  int checks = 0;
  int failures = 0;
  logic [59:0] q[$];
  logic [59:0] q4[$];
  bit sb4_en = 1'b0;
  int occ4 = 0;

  always #5 i_clk = ~i_clk;

  match_pair_collector #(.DEPTH(64), .CNT_W(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .i_valid(i_valid),
    .i_src_coor_x(sx), .i_src_coor_y(sy), .i_src_depth(sd),
    .i_dst_coor_x(dx), .i_dst_coor_y(dy), .i_dst_depth(dd),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_src_coor_x(osx), .o_src_coor_y(osy), .o_src_depth(osd),
    .o_dst_coor_x(odx), .o_dst_coor_y(ody), .o_dst_depth(odd),
    .o_frame_done(o_frame_done), .o_match_count(o_match_count), .o_drop_count(o_drop_count),
    .o_overflow(o_overflow), .o_proto_err(o_proto_err)
  );

  match_pair_collector #(.DEPTH(4), .CNT_W(3)) dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .i_valid(i_valid),
    .i_src_coor_x(sx), .i_src_coor_y(sy), .i_src_depth(sd),
    .i_dst_coor_x(dx), .i_dst_coor_y(dy), .i_dst_depth(dd),
    .o_valid(o4_valid), .i_ready(i_ready),
    .o_src_coor_x(o4sx), .o_src_coor_y(o4sy), .o_src_depth(o4sd),
    .o_dst_coor_x(o4dx), .o_dst_coor_y(o4dy), .o_dst_depth(o4dd),
    .o_frame_done(o4_frame_done), .o_match_count(o4_match_count), .o_drop_count(o4_drop_count),
    .o_overflow(o4_overflow), .o_proto_err(o4_proto_err)
  );

  // Output-side scoreboards: a handshake seen at the negedge pops at the next posedge.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL main_unexpected_out got=%h expected=none", o_pair);
      end else begin
        logic [59:0] e;
        e = q.pop_front();
        if (o_pair !== e) begin
          failures++;
          $display("FAIL main_out_data got=%h expected=%h", o_pair, e);
        end
      end
    end
    if (sb4_en && !i_rst && o4_valid && i_ready) begin
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL d4_unexpected_out got=%h expected=none", o4_pair);
      end else begin
        logic [59:0] e;
        e = q4.pop_front();
        if (o4_pair !== e) begin
          failures++;
          $display("FAIL d4_out_data got=%h expected=%h", o4_pair, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_frame_start = 0; i_frame_end = 0; i_valid = 0;
    sx = 0; sy = 0; sd = 0; dx = 0; dy = 0; dd = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    q.delete();
    q4.delete();
    occ4 = 0;
  endtask

  // Drives one pair for one cycle and records what each instance should store.
  task automatic send_pair(input logic [9:0] s_d, input logic [9:0] d_d, output logic [59:0] p);
    sx = 10'($urandom_range(0, 1023)); sy = 10'($urandom_range(0, 1023)); sd = s_d;
    dx = 10'($urandom_range(0, 1023)); dy = 10'($urandom_range(0, 1023)); dd = d_d;
    p = {sx, sy, sd, dx, dy, dd};
    if (s_d != 0 && d_d != 0) begin
      q.push_back(p);
      if (sb4_en && occ4 < 4) begin
        q4.push_back(p);
        occ4++;
      end
    end
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic pulse_start();
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    i_frame_end = 1'b1; tick(); i_frame_end = 1'b0;
  endtask

  task automatic wait_done(input bit sel4, input int budget, output int cyc, output bit got);
    cyc = 0;
    while (!(sel4 ? o4_frame_done : o_frame_done) && cyc < budget) begin
      tick();
      cyc++;
    end
    got = sel4 ? o4_frame_done : o_frame_done;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b expected=0", o_valid); end
    checks++; if (o_pair !== 60'd0) begin failures++; $display("FAIL reset_data got=%h expected=0", o_pair); end
    checks++; if ({o_frame_done, o_overflow, o_proto_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b expected=000", {o_frame_done, o_overflow, o_proto_err}); end
    checks++; if ({o_match_count, o_drop_count} !== 20'd0) begin
      failures++; $display("FAIL reset_counts got=%0d/%0d expected=0/0", o_match_count, o_drop_count); end
  endtask

  task automatic test_basic();
    logic [59:0] p0, p1, p2;
    i_ready = 1'b1;
    pulse_start();
    send_pair(10'd5, 10'd5, p0);
    checks++; if (o_valid !== 1'b1 || o_pair !== p0) begin
      failures++; $display("FAIL basic_first_latency got=%b/%h expected=1/%h", o_valid, o_pair, p0); end
    send_pair(10'd6, 10'd6, p1);
    send_pair(10'd7, 10'd7, p2);
    pulse_end();
    checks++; if (o_frame_done !== 1'b1) begin
      failures++; $display("FAIL basic_done_timing got=%b expected=1", o_frame_done); end
    checks++; if (o_match_count !== 10'd3 || o_drop_count !== 10'd0) begin
      failures++; $display("FAIL basic_counts got=%0d/%0d expected=3/0", o_match_count, o_drop_count); end
    tick();
    checks++; if (o_frame_done !== 1'b0 || o_match_count !== 10'd3) begin
      failures++; $display("FAIL basic_done_pulse got=%b/%0d expected=0/3", o_frame_done, o_match_count); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL basic_left got=%0d expected=0", q.size()); end
  endtask

  task automatic test_backpressure();
    logic [59:0] p, first;
    int cyc; bit got;
    i_ready = 1'b0;
    pulse_start();
    send_pair(10'd9, 10'd3, first);
    for (int i = 0; i < 4; i++) send_pair(10'($urandom_range(1, 1023)), 10'($urandom_range(1, 1023)), p);
    pulse_end();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_pair !== first || o_frame_done !== 1'b0) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h expected=1/%h", i, o_valid, o_pair, first); end
      tick();
    end
    i_ready = 1'b1;
    wait_done(1'b0, 50, cyc, got);
    checks++; if (!got || cyc != 5) begin
      failures++; $display("FAIL bp_done got=%b after %0d expected=1 after 5", got, cyc); end
    checks++; if (o_match_count !== 10'd5 || o_drop_count !== 10'd0) begin
      failures++; $display("FAIL bp_counts got=%0d/%0d expected=5/0", o_match_count, o_drop_count); end
    tick();
  endtask

  task automatic test_depth_filter();
    logic [59:0] p;
    int cyc; bit got;
    i_ready = 1'b1;
    pulse_start();
    send_pair(10'd4, 10'd8, p);
    send_pair(10'd0, 10'd8, p);
    send_pair(10'd4, 10'd0, p);
    send_pair(10'd1023, 10'd1, p);
    pulse_end();
    wait_done(1'b0, 20, cyc, got);
    checks++; if (!got) begin failures++; $display("FAIL filter_done got=0 expected=1"); end
    checks++; if (o_match_count !== 10'd2 || o_drop_count !== 10'd2 || o_overflow !== 1'b0) begin
      failures++; $display("FAIL filter_counts got=%0d/%0d/%b expected=2/2/0", o_match_count, o_drop_count, o_overflow); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL filter_left got=%0d expected=0", q.size()); end
    tick();
  endtask

  task automatic test_overflow();
    logic [59:0] p;
    int cyc; bit got;
    do_reset();
    sb4_en = 1'b1;
    i_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) send_pair(10'(i + 1), 10'(i + 2), p);
    pulse_end();
    checks++; if (o4_match_count !== 3'd4 || o4_drop_count !== 3'd2 || o4_overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_counts got=%0d/%0d/%b expected=4/2/1", o4_match_count, o4_drop_count, o4_overflow); end
    checks++; if (o_match_count !== 10'd6 || o_overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_main_counts got=%0d/%b expected=6/0", o_match_count, o_overflow); end
    i_ready = 1'b1;
    wait_done(1'b1, 20, cyc, got);
    checks++; if (!got || cyc != 4) begin
      failures++; $display("FAIL ovf_done got=%b after %0d expected=1 after 4", got, cyc); end
    checks++; if (q4.size() != 0) begin failures++; $display("FAIL ovf_left got=%0d expected=0", q4.size()); end
    wait_done(1'b0, 20, cyc, got);
    checks++; if (!got) begin failures++; $display("FAIL ovf_main_done got=0 expected=1"); end
    tick();
    pulse_start();
    checks++; if (o4_overflow !== 1'b0 || o4_match_count !== 3'd0) begin
      failures++; $display("FAIL ovf_clear got=%b/%0d expected=0/0", o4_overflow, o4_match_count); end
    pulse_end();
    tick();
    sb4_en = 1'b0;
  endtask

  task automatic test_saturate();
    logic [59:0] p;
    int cyc; bit got;
    do_reset();
    i_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) send_pair(10'd0, 10'(i), p);
    pulse_end();
    wait_done(1'b0, 10, cyc, got);
    checks++; if (o4_drop_count !== 3'd7 || o4_match_count !== 3'd0) begin
      failures++; $display("FAIL sat_small got=%0d/%0d expected=7/0", o4_drop_count, o4_match_count); end
    checks++; if (o_drop_count !== 10'd10) begin
      failures++; $display("FAIL sat_main got=%0d expected=10", o_drop_count); end
    tick();
  endtask

  task automatic test_empty_and_proto();
    logic [59:0] p;
    int cyc; bit got;
    do_reset();
    i_ready = 1'b1;
    // A valid pair alongside the start pulse must not be counted.
    i_frame_start = 1'b1; i_valid = 1'b1; sd = 10'd3; dd = 10'd3; sx = 10'd77;
    tick();
    clear_inputs();
    pulse_end();
    checks++; if (o_frame_done !== 1'b1 || o_match_count !== 10'd0 || o_drop_count !== 10'd0 || o_valid !== 1'b0) begin
      failures++; $display("FAIL empty_frame got=%b/%0d/%0d/%b expected=1/0/0/0", o_frame_done, o_match_count, o_drop_count, o_valid); end
    tick();
    checks++; if (o_proto_err !== 1'b0) begin failures++; $display("FAIL proto_pre got=%b expected=0", o_proto_err); end
    pulse_end();
    checks++; if (o_proto_err !== 1'b1) begin failures++; $display("FAIL proto_end_idle got=%b expected=1", o_proto_err); end
    tick(); tick(); tick();
    checks++; if (o_proto_err !== 1'b1) begin failures++; $display("FAIL proto_sticky got=%b expected=1", o_proto_err); end
    do_reset();
    checks++; if (o_proto_err !== 1'b0) begin failures++; $display("FAIL proto_reset got=%b expected=0", o_proto_err); end
    pulse_start();
    send_pair(10'd2, 10'd2, p);
    pulse_start();
    checks++; if (o_proto_err !== 1'b1) begin failures++; $display("FAIL proto_start_collect got=%b expected=1", o_proto_err); end
    send_pair(10'd3, 10'd3, p);
    pulse_end();
    wait_done(1'b0, 10, cyc, got);
    checks++; if (!got || o_match_count !== 10'd2) begin
      failures++; $display("FAIL proto_continue got=%b/%0d expected=1/2", got, o_match_count); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [59:0] p;
    do_reset();
    i_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) send_pair(10'd5, 10'd5, p);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    q.delete();
    checks++; if (o_valid !== 1'b0 || o_match_count !== 10'd0 || o_drop_count !== 10'd0 || o_frame_done !== 1'b0) begin
      failures++; $display("FAIL midrst got=%b/%0d/%0d/%b expected=0/0/0/0", o_valid, o_match_count, o_drop_count, o_frame_done); end
    test_basic();
  endtask

  initial begin
    i_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_depth_filter();
    test_overflow();
    test_saturate();
    test_empty_and_proto();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
